// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Contents:
//   SZ_*          RISC-V funct3 access-size encodings
//   dmem_state_e  responder FSM states
//   size_illegal  flags funct3 values with no load/store meaning
//   sat_inc16     saturating 16-bit increment for the statistics counters
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmem_state_e;

    function automatic logic size_illegal(input logic [2:0] size);
        return (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data-memory responder (purely combinational).
// Ports:
//   size_i      funct3 access size
//   addr_lo_i   byte offset within the word
//   wdata_i     right-aligned store data
//   rdata_i     raw 32-bit word read from storage
//   be_o        byte write mask
//   wdata_o     store data replicated onto the addressed lanes
//   rdata_o     load data shifted to bit 0 and sign/zero extended
//   misalign_o  halfword on odd address or word not on a 4-byte boundary
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = 32'h0;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (size_i)
            SZ_B, SZ_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = (size_i == SZ_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                           : {24'h0, shifted[7:0]};
            end
            SZ_H, SZ_HU: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = (size_i == SZ_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                              : {16'h0, shifted[15:0]};
            end
            SZ_W: begin
                misalign_o = |addr_lo_i;
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                rdata_o    = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: far end of the memory-stage load/store interface.
// Accepts one request per handshake, waits WAIT_CYCLES, then performs the
// byte/half/word access and emits a one-cycle response pulse.
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   req_valid_i/ready_o  request handshake
//   req_we_i, req_addr_i, req_wdata_i, req_size_i  request fields (funct3 size)
//   rsp_valid_o       one-cycle response pulse
//   rsp_rdata_o       extended load data; 0 for stores and errors
//   rsp_err_o         misaligned, out-of-range or illegal size
// Optional (macro DMEM_STATS_EN): stat_loads_o, stat_stores_o, stat_errs_o
// saturating 16-bit event counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [2:0]        req_size_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       stat_loads_o,
    output logic [15:0]       stat_stores_o,
    output logic [15:0]       stat_errs_o
`endif
);

    localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0] mem_q [DEPTH_WORDS];

    dmem_state_e       state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        size_q;
    logic [3:0]        cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    // With zero wait states the access happens on the accepting edge, so the
    // live request fields are used in IDLE and the latched copy otherwise.
    logic              in_idle;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [2:0]        acc_size;

    assign in_idle   = (state_q == StIdle);
    assign acc_we    = in_idle ? req_we_i    : we_q;
    assign acc_addr  = in_idle ? req_addr_i  : addr_q;
    assign acc_wdata = in_idle ? req_wdata_i : wdata_q;
    assign acc_size  = in_idle ? req_size_i  : size_q;

    logic [ADDR_W-3:0] acc_widx;
    logic [IdxW-1:0]   mem_idx;
    logic              out_of_range;
    logic              size_bad;
    logic              misalign;
    logic              acc_err;
    logic [3:0]        be;
    logic [31:0]       wdata_al;
    logic [31:0]       ld_data;
    logic              enter_resp;
    logic              mem_we;

    assign acc_widx     = acc_addr[ADDR_W-1:2];
    assign mem_idx      = acc_widx[IdxW-1:0];
    assign out_of_range = 64'(acc_widx) >= 64'(DEPTH_WORDS);
    assign size_bad     = size_illegal(acc_size) ||
                          (acc_we && ((acc_size == SZ_BU) || (acc_size == SZ_HU)));
    assign acc_err      = size_bad || misalign || out_of_range;

    dmem_lane_align u_lane_align (
        .size_i     (acc_size),
        .addr_lo_i  (acc_addr[1:0]),
        .wdata_i    (acc_wdata),
        .rdata_i    (mem_q[mem_idx]),
        .be_o       (be),
        .wdata_o    (wdata_al),
        .rdata_o    (ld_data),
        .misalign_o (misalign)
    );

    assign enter_resp = (in_idle && req_valid_i && (WAIT_CYCLES == 0)) ||
                        ((state_q == StWait) && (cnt_q == 4'd0));
    assign mem_we     = enter_resp && acc_we && !acc_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            rsp_valid_q <= enter_resp;
            if (enter_resp) begin
                rsp_err_q   <= acc_err;
                rsp_rdata_q <= (acc_err || acc_we) ? 32'h0 : ld_data;
            end
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        we_q        <= req_we_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        size_q      <= req_size_i;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CntInit;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) state_q <= StResp;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                StResp: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage is never cleared; reset low on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[mem_idx][8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

`ifdef DMEM_STATS_EN
    logic [15:0] stat_loads_q;
    logic [15:0] stat_stores_q;
    logic [15:0] stat_errs_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_loads_q  <= 16'h0;
            stat_stores_q <= 16'h0;
            stat_errs_q   <= 16'h0;
        end else if (enter_resp) begin
            if (acc_err)     stat_errs_q   <= sat_inc16(stat_errs_q);
            else if (acc_we) stat_stores_q <= sat_inc16(stat_stores_q);
            else             stat_loads_q  <= sat_inc16(stat_loads_q);
        end
    end

    assign stat_loads_o  = stat_loads_q;
    assign stat_stores_o = stat_stores_q;
    assign stat_errs_o   = stat_errs_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAITC = 1;
    localparam int          NV    = 25;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_STATS_EN
    logic [15:0] stat_loads;
    logic [15:0] stat_stores;
    logic [15:0] stat_errs;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (32),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_size_i  (req_size),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
`ifdef DMEM_STATS_EN
        ,
        .stat_loads_o  (stat_loads),
        .stat_stores_o (stat_stores),
        .stat_errs_o   (stat_errs)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request from a falling edge; returns the response fields, the
    // number of rising edges from accept to the pulse, and handshake status.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, output logic [31:0] rd, output logic er,
                          output int lat, output logic rdy_after, output logic pulse_clr);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        @(negedge clk);
        rdy_after = req_ready;
        // Scramble the fields: the responder must use its latched copy.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 3'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        pulse_clr = !rsp_valid;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        rdy_after;
        logic        pulse_clr;
        int          nacc;
        int          nrsp;
        int          last_acc;
        int          stray;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, SZ_W,   32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        SZ_W,   32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h13,  32'h00000080, SZ_B,   32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h13,  32'h0,        SZ_B,   32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,  32'h0,        SZ_BU,  32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, 32'h10,  32'h0,        SZ_W,   32'h80ADBEEF, 1'b0};
        vecs[6]  = '{1'b0, 32'h12,  32'h0,        SZ_B,   32'hFFFFFFAD, 1'b0};
        vecs[7]  = '{1'b0, 32'h10,  32'h0,        SZ_H,   32'hFFFFBEEF, 1'b0};
        vecs[8]  = '{1'b0, 32'h12,  32'h0,        SZ_HU,  32'h000080AD, 1'b0};
        vecs[9]  = '{1'b1, 32'h20,  32'h11223344, SZ_W,   32'h0,        1'b0};
        vecs[10] = '{1'b1, 32'h22,  32'hAAAA8001, SZ_H,   32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h22,  32'h0,        SZ_H,   32'hFFFF8001, 1'b0};
        vecs[12] = '{1'b0, 32'h22,  32'h0,        SZ_HU,  32'h00008001, 1'b0};
        vecs[13] = '{1'b0, 32'h21,  32'h0,        SZ_H,   32'h0,        1'b1};
        vecs[14] = '{1'b0, 32'h20,  32'h0,        SZ_W,   32'h80013344, 1'b0};
        vecs[15] = '{1'b0, 32'h1000, 32'h0,       SZ_W,   32'h0,        1'b1};
        vecs[16] = '{1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1};
        vecs[17] = '{1'b1, 32'h11,  32'hFFFFFFFF, SZ_W,   32'h0,        1'b1};
        vecs[18] = '{1'b1, 32'h10,  32'h00000000, SZ_BU,  32'h0,        1'b1};
        vecs[19] = '{1'b0, 32'h10,  32'h0,        SZ_W,   32'h80ADBEEF, 1'b0};
        vecs[20] = '{1'b1, 32'hFFC, 32'h5A5A5A5A, SZ_W,   32'h0,        1'b0};
        vecs[21] = '{1'b0, 32'hFFC, 32'h0,        SZ_W,   32'h5A5A5A5A, 1'b0};
        vecs[22] = '{1'b0, 32'h11,  32'h0,        3'b110, 32'h0,        1'b1};
        vecs[23] = '{1'b1, 32'h10,  32'h000001FF, SZ_B,   32'h0,        1'b0};
        vecs[24] = '{1'b0, 32'h10,  32'h0,        SZ_BU,  32'h000000FF, 1'b0};

        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_size  = SZ_W;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                   rd, er, lat, rdy_after, pulse_clr);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(WAITC));
            chk($sformatf("vec%0d_busy_after_accept", i), {31'b0, rdy_after}, 32'd0);
            chk($sformatf("vec%0d_single_pulse", i), {31'b0, pulse_clr}, 32'd1);
        end

        // Back-to-back: req_valid held high with a fixed load.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h20;
        req_size  = SZ_W;
        nacc      = 0;
        nrsp      = 0;
        last_acc  = -1;
        for (int c = 0; c < 12; c++) begin
            if (req_ready) begin
                if (last_acc >= 0) chk("b2b_accept_spacing", 32'(c - last_acc), 32'(WAITC + 2));
                last_acc = c;
                nacc++;
            end
            if (rsp_valid) begin
                nrsp++;
                chk("b2b_rdata", rsp_rdata, 32'h80013344);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid) begin
                nrsp++;
                chk("b2b_rdata", rsp_rdata, 32'h80013344);
            end
            @(negedge clk);
        end
        chk("b2b_accept_count", 32'(nacc), 32'd4);
        chk("b2b_response_count", 32'(nrsp), 32'(nacc));

        // Reset during WAIT drops the pending store.
        do_req(1'b1, 32'h30, 32'hCAFEF00D, SZ_W, rd, er, lat, rdy_after, pulse_clr);
        chk("rst_prestore_err", {31'b0, er}, 32'd0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_size  = SZ_W;
        @(negedge clk);
        chk("rst_in_wait_busy", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        chk("rst_abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_release_rdata", rsp_rdata, 32'h0);
        chk("rst_release_err", {31'b0, rsp_err}, 32'd0);
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid) stray++;
            @(negedge clk);
        end
        chk("rst_no_stray_rsp", 32'(stray), 32'd0);
        do_req(1'b0, 32'h30, 32'h0, SZ_W, rd, er, lat, rdy_after, pulse_clr);
        chk("rst_store_dropped", rd, 32'hCAFEF00D);
        chk("rst_reload_err", {31'b0, er}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
